// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: shared-memory handshake, ALU decode and sticky illegal-opcode trap.
// Optional retire counter is built when CTRL_RETIRE_CNT_EN is defined.
module multicycle_controller #(
    parameter int unsigned ALU_CTRL_W = 3,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  Zero,
    input  logic                  mem_ready,
    output logic                  MemReq,
    output logic                  MemWrite,
    output logic                  AdrSrc,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  RegWrite,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  illegal
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]      retire_cnt
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam bit WIDE_ALU = (ALU_CTRL_W == 4);

    if (ALU_CTRL_W != 3 && ALU_CTRL_W != 4) begin : g_bad_alu_w
        $error("multicycle_controller: ALU_CTRL_W must be 3 or 4");
    end
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("multicycle_controller: CNT_W must be at least 1");
    end

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BEQ, S_TRAP
    } state_e;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       mem_req, mem_wr, adr_src, ir_wr, pc_wr, reg_wr;
    logic [1:0] src_a, src_b, res_src, alu_op, imm_src;
    logic [3:0] alu_full;

    // State and sticky trap flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal_d = illegal_q | (state_d == S_TRAP);

    // Next state and per-state datapath controls
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        mem_wr  = 1'b0;
        adr_src = 1'b0;
        ir_wr   = 1'b0;
        pc_wr   = 1'b0;
        reg_wr  = 1'b0;
        src_a   = 2'b00;
        src_b   = 2'b00;
        res_src = 2'b00;
        alu_op  = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                src_b   = 2'b10;
                res_src = 2'b10;
                if (mem_ready) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                res_src = 2'b01;
                reg_wr  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                src_a   = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wr  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                src_a   = 2'b01;
                src_b   = 2'b10;
                pc_wr   = 1'b1;
                state_d = S_ALUWB;
            end
            S_BEQ: begin
                src_a   = 2'b10;
                alu_op  = 2'b01;
                pc_wr   = Zero;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Immediate format straight from the instruction register opcode
    always_comb begin
        imm_src = 2'b00;
        case (opcode)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    // ALU decode; the narrow build falls back to add for ops it cannot encode
    always_comb begin
        alu_full = ALU_ADD;
        case (alu_op)
            2'b01: alu_full = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000: alu_full = (opcode[5] && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010: alu_full = ALU_SLT;
                    3'b110: alu_full = ALU_OR;
                    3'b111: alu_full = ALU_AND;
                    3'b100: alu_full = WIDE_ALU ? ALU_XOR : ALU_ADD;
                    3'b001: alu_full = WIDE_ALU ? ALU_SLL : ALU_ADD;
                    3'b101: alu_full = WIDE_ALU ? (funct7_5 ? ALU_SRA : ALU_SRL) : ALU_ADD;
                    3'b011: alu_full = WIDE_ALU ? ALU_SLTU : ALU_ADD;
                endcase
            end
            default: alu_full = ALU_ADD;
        endcase
    end

    // Everything is forced low while reset is held, even though the state sits in FETCH
    assign MemReq     = rst_n & mem_req;
    assign MemWrite   = rst_n & mem_wr;
    assign AdrSrc     = rst_n & adr_src;
    assign IRWrite    = rst_n & ir_wr;
    assign PCWrite    = rst_n & pc_wr;
    assign RegWrite   = rst_n & reg_wr;
    assign ALUSrcA    = rst_n ? src_a   : 2'b00;
    assign ALUSrcB    = rst_n ? src_b   : 2'b00;
    assign ResultSrc  = rst_n ? res_src : 2'b00;
    assign ImmSrc     = rst_n ? imm_src : 2'b00;
    assign ALUControl = rst_n ? ALU_CTRL_W'(alu_full) : '0;
    assign illegal    = illegal_q;

`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_q;
    logic             retire_c;

    // An instruction retires on the edge that returns the FSM to FETCH
    assign retire_c = (state_d == S_FETCH) &&
                      (state_q == S_MEMWB || state_q == S_MEMWRITE ||
                       state_q == S_ALUWB || state_q == S_BEQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q <= '0;
        end else if (retire_c) begin
            retire_q <= retire_q + CNT_W'(1);
        end
    end

    assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-template reference model, directed pins, random stimulus.
module tb_multicycle_controller;

    localparam int unsigned CNT_W = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = OP_RTYPE;
    logic [2:0] funct3 = 3'b000;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       req3, wr3, adr3, irw3, pcw3, rw3, ill3;
    logic [1:0] sa3, sb3, rs3, imm3;
    logic [2:0] alu3;
    logic       req4, wr4, adr4, irw4, pcw4, rw4, ill4;
    logic [1:0] sa4, sb4, rs4, imm4;
    logic [3:0] alu4;
`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] rc3, rc4;
`endif

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.ALU_CTRL_W(3), .CNT_W(CNT_W)) dut3 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(zero), .mem_ready(mem_ready), .MemReq(req3), .MemWrite(wr3), .AdrSrc(adr3),
        .IRWrite(irw3), .PCWrite(pcw3), .RegWrite(rw3), .ALUSrcA(sa3), .ALUSrcB(sb3),
        .ResultSrc(rs3), .ImmSrc(imm3), .ALUControl(alu3), .illegal(ill3)
`ifdef CTRL_RETIRE_CNT_EN
        , .retire_cnt(rc3)
`endif
    );

    multicycle_controller #(.ALU_CTRL_W(4), .CNT_W(CNT_W)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(zero), .mem_ready(mem_ready), .MemReq(req4), .MemWrite(wr4), .AdrSrc(adr4),
        .IRWrite(irw4), .PCWrite(pcw4), .RegWrite(rw4), .ALUSrcA(sa4), .ALUSrcB(sb4),
        .ResultSrc(rs4), .ImmSrc(imm4), .ALUControl(alu4), .illegal(ill4)
`ifdef CTRL_RETIRE_CNT_EN
        , .retire_cnt(rc4)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: each instruction is a fixed list of micro-steps ----------------
    typedef enum int {K_LOAD, K_STORE, K_R, K_I, K_JAL, K_BEQ, K_TRAP} kind_e;
    typedef struct packed {
        logic       req, wr, adr, irw, pcw, rw;
        logic [1:0] sa, sb, rs, aluop;
    } step_t;

    function automatic kind_e classify(input logic [6:0] op);
        case (op)
            OP_LOAD:   return K_LOAD;
            OP_STORE:  return K_STORE;
            OP_RTYPE:  return K_R;
            OP_ITYPE:  return K_I;
            OP_JAL:    return K_JAL;
            OP_BRANCH: return K_BEQ;
            default:   return K_TRAP;
        endcase
    endfunction

    function automatic int nsteps(input kind_e k);
        case (k)
            K_LOAD:  return 3;
            K_BEQ:   return 1;
            default: return 2;
        endcase
    endfunction

    function automatic bit is_wait(input kind_e k, input int idx);
        return (k == K_LOAD || k == K_STORE) && idx == 1;
    endfunction

    // ph 0 = instruction fetch, ph 1 = decode, ph >= 2 = class-specific steps
    function automatic step_t step_exp(input int ph, input kind_e k, input logic rdy, input logic z);
        step_t e = '0;
        int idx = ph - 2;
        if (ph == 0) begin
            e.req = 1'b1; e.sb = 2'd2; e.rs = 2'd2; e.irw = rdy; e.pcw = rdy;
        end else if (ph == 1) begin
            e.sa = 2'd1; e.sb = 2'd1;
        end else begin
            case (k)
                K_LOAD:  if (idx == 0) begin e.sa = 2'd2; e.sb = 2'd1; end
                         else if (idx == 1) begin e.req = 1'b1; e.adr = 1'b1; end
                         else begin e.rs = 2'd1; e.rw = 1'b1; end
                K_STORE: if (idx == 0) begin e.sa = 2'd2; e.sb = 2'd1; end
                         else begin e.req = 1'b1; e.wr = 1'b1; e.adr = 1'b1; end
                K_R:     if (idx == 0) begin e.sa = 2'd2; e.aluop = 2'd2; end
                         else e.rw = 1'b1;
                K_I:     if (idx == 0) begin e.sa = 2'd2; e.sb = 2'd1; e.aluop = 2'd2; end
                         else e.rw = 1'b1;
                K_JAL:   if (idx == 0) begin e.sa = 2'd1; e.sb = 2'd2; e.pcw = 1'b1; end
                         else e.rw = 1'b1;
                K_BEQ:   begin e.sa = 2'd2; e.aluop = 2'd1; e.pcw = z; end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    // Mnemonic table: add 0, sub 1, and 2, or 3, xor 4, slt 5, sll 6, srl 7, sra 8, sltu 9
    function automatic int alu_exp(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                                   input logic op5, input bit wide);
        if (aop == 2'd1) return 1;
        if (aop != 2'd2) return 0;
        case (f3)
            3'b000: return (op5 && f7) ? 1 : 0;
            3'b010: return 5;
            3'b110: return 3;
            3'b111: return 2;
            3'b100: return wide ? 4 : 0;
            3'b001: return wide ? 6 : 0;
            3'b101: return wide ? (f7 ? 8 : 7) : 0;
            default: return wide ? 9 : 0;
        endcase
    endfunction

    function automatic logic [1:0] imm_exp(input logic [6:0] op);
        case (op)
            OP_STORE:  return 2'd1;
            OP_BRANCH: return 2'd2;
            OP_JAL:    return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

    int          m_ph;
    kind_e       m_kind;
    int unsigned m_ret;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph   <= 0;
            m_kind <= K_R;
            m_ret  <= 0;
        end else if (m_ph == 0) begin
            if (mem_ready) m_ph <= 1;
        end else if (m_ph == 1) begin
            m_kind <= classify(opcode);
            m_ph   <= 2;
        end else if (m_kind != K_TRAP) begin
            if (!(is_wait(m_kind, m_ph - 2) && !mem_ready)) begin
                if (m_ph - 2 == nsteps(m_kind) - 1) begin
                    m_ph  <= 0;
                    m_ret <= (m_ret + 1) % (1 << CNT_W);
                end else begin
                    m_ph <= m_ph + 1;
                end
            end
        end
    end

    // Per-cycle comparison of both widths against the model
    always @(negedge clk) begin
        step_t       e;
        logic [14:0] ev, a3, a4;
        int          ea3, ea4;
        logic        ill_e;
        a3 = {req3, wr3, adr3, irw3, pcw3, rw3, sa3, sb3, rs3, imm3, ill3};
        a4 = {req4, wr4, adr4, irw4, pcw4, rw4, sa4, sb4, rs4, imm4, ill4};
        if (!rst_n) begin
            ev = '0; ea3 = 0; ea4 = 0;
        end else begin
            e     = step_exp(m_ph, m_kind, mem_ready, zero);
            ill_e = (m_kind == K_TRAP) && (m_ph >= 2);
            ev    = {e.req, e.wr, e.adr, e.irw, e.pcw, e.rw, e.sa, e.sb, e.rs, imm_exp(opcode), ill_e};
            ea3   = alu_exp(e.aluop, funct3, funct7_5, opcode[5], 1'b0);
            ea4   = alu_exp(e.aluop, funct3, funct7_5, opcode[5], 1'b1);
        end
        check("ctrl_w3", 32'(a3), 32'(ev));
        check("ctrl_w4", 32'(a4), 32'(ev));
        check("aluctl_w3", 32'(alu3), 32'(ea3 & 7));
        check("aluctl_w4", 32'(alu4), 32'(ea4));
`ifdef CTRL_RETIRE_CNT_EN
        check("retire_w3", 32'(rc3), 32'(m_ret));
        check("retire_w4", 32'(rc4), 32'(m_ret));
`endif
    end

    // ---------------- directed instruction runner ----------------
    logic [31:0] rw_h, req_h, adr_h, pcw_h;
    logic [1:0]  rs_h   [32];
    logic [2:0]  alu3_h [32];
    logic [3:0]  alu4_h [32];

    // Starts at posedge+1 idling in FETCH; returns cycle count, or -1 if FETCH never comes back
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input logic [31:0] stall, output int n);
        bit left = 1'b0;
        n = -1;
        rw_h = '0; req_h = '0; adr_h = '0; pcw_h = '0;
        opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
        for (int c = 1; c <= 24; c++) begin
            if (left && req3 && !adr3) begin
                n = c - 1;
                break;
            end
            mem_ready = ~stall[c];
            @(negedge clk);
            rw_h[c] = rw3; req_h[c] = req3; adr_h[c] = adr3; pcw_h[c] = pcw3;
            rs_h[c] = rs3; alu3_h[c] = alu3; alu4_h[c] = alu4;
            if (!(req3 && !adr3)) left = 1'b1;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] legal_ops [6];

    initial begin
        int n;
        legal_ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_memreq", 32'(req3), 32'd0);
        check("reset_srcb", 32'(sb3), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_fetch_memreq", 32'(req3), 32'd1);
        @(posedge clk); #1;

        run_instr(OP_RTYPE, 3'b000, 1'b0, 1'b0, 32'h0, n);
        check("add_cycles", 32'(n), 32'd4);
        check("add_regwrite_c4_only", 32'(rw_h[4:1]), 32'b1000);
        check("add_aluctl", 32'(alu4_h[3]), 32'd0);

        run_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 32'h30, n);
        check("lw_wait_cycles", 32'(n), 32'd7);
        check("lw_memreq_held", 32'(req_h[6:4]), 32'b111);
        check("lw_adrsrc_held", 32'(adr_h[6:4]), 32'b111);
        check("lw_regwrite_after_ready", 32'(rw_h[7:6]), 32'b10);
        check("lw_resultsrc", 32'(rs_h[7]), 32'd1);

        run_instr(OP_BRANCH, 3'b000, 1'b0, 1'b1, 32'h0, n);
        check("beq_taken_cycles", 32'(n), 32'd3);
        check("beq_taken_pcwrite", 32'(pcw_h[3]), 32'd1);
        run_instr(OP_BRANCH, 3'b000, 1'b0, 1'b0, 32'h0, n);
        check("beq_not_taken_cycles", 32'(n), 32'd3);
        check("beq_not_taken_pcwrite", 32'(pcw_h[3]), 32'd0);

        run_instr(OP_RTYPE, 3'b101, 1'b1, 1'b0, 32'h0, n);
        check("sra_w4", 32'(alu4_h[3]), 32'd8);
        check("sra_w3", 32'(alu3_h[3]), 32'd0);
        run_instr(OP_RTYPE, 3'b100, 1'b0, 1'b0, 32'h0, n);
        check("xor_w3_add", 32'(alu3_h[3]), 32'd0);
        check("xor_w4", 32'(alu4_h[3]), 32'd4);
        run_instr(OP_RTYPE, 3'b000, 1'b1, 1'b0, 32'h0, n);
        check("sub_w3", 32'(alu3_h[3]), 32'd1);

        run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 32'h0, n);
        check("sw_cycles", 32'(n), 32'd4);
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 32'h0, n);
        check("jal_cycles", 32'(n), 32'd4);
        run_instr(OP_ITYPE, 3'b000, 1'b0, 1'b0, 32'h2, n);
        check("addi_fetch_wait_cycles", 32'(n), 32'd5);

        run_instr(OP_SYSTEM, 3'b000, 1'b0, 1'b0, 32'h0, n);
        check("trap_no_return", 32'(n), 32'hFFFF_FFFF);
        check("trap_no_memreq", 32'(req_h[24:3]), 32'd0);
        check("trap_illegal", 32'(ill3), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("trap_reset_illegal", 32'(ill3), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("trap_reset_fetch", 32'(req3), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) run_instr(OP_RTYPE, 3'b000, 1'b0, 1'b0, 32'h0, n);
`ifdef CTRL_RETIRE_CNT_EN
        check("retire_wrap", 32'(rc3), 32'd1);
`endif
        opcode = OP_RTYPE; funct3 = 3'b000; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_no_regwrite", 32'(rw3), 32'd0);
`ifdef CTRL_RETIRE_CNT_EN
        check("abort_retire_clear", 32'(rc3), 32'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1; mem_ready = 1'b0;

        // Random instruction mix with memory stalls and occasional mid-instruction resets
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 199) == 0 || (m_kind == K_TRAP && m_ph >= 2 && $urandom_range(0, 7) == 0)) begin
                rst_n = 1'b0;
                @(posedge clk); #1 rst_n = 1'b1;
            end
            if (m_ph == 0) begin
                if ($urandom_range(0, 15) == 0) opcode = 7'($urandom);
                else opcode = legal_ops[$urandom_range(0, 5)];
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            zero      = 1'($urandom);
            funct3    = 3'($urandom);
            funct7_5  = 1'($urandom);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
